// File: rtl/lcd_pkg.sv
// Shared LCD command bytes, line geometry and arbiter state encoding.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h3C;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ADDR_L1  = 8'h80;
    localparam logic [7:0] CMD_ADDR_L2  = 8'hC0;

    localparam logic [3:0] LAST_CHAR = 4'd15;

    typedef enum logic [3:0] {
        ST_INIT_FS, ST_INIT_ON, ST_INIT_EM, ST_INIT_CLR, ST_CLR_WAIT,
        ST_IDLE, ST_ADDR, ST_CHAR, ST_FIN
    } state_t;

    // States that put a byte on the bus and therefore need a write slot.
    function automatic logic is_write(state_t s);
        return s inside {ST_INIT_FS, ST_INIT_ON, ST_INIT_EM, ST_INIT_CLR, ST_ADDR, ST_CHAR};
    endfunction

endpackage

// File: rtl/lcd_write_slot.sv
// One LCD write slot: E_DIV cycles with lcd_e low, then E_DIV cycles high.
// 'load' marks the edge at which the next slot begins, so slots can run back to back.
module lcd_write_slot #(
    parameter int E_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic want,
    output logic load,
    output logic done,
    output logic lcd_e
);

    localparam int CW = $clog2(2 * E_DIV);

    logic          busy;
    logic [CW-1:0] cnt;

    assign done  = busy && (cnt == CW'(2 * E_DIV - 1));
    assign load  = want && (!busy || done);
    assign lcd_e = busy && (cnt >= CW'(E_DIV));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_line_arbiter.sv
// Two-requester arbiter for a 16x2 character LCD: runs the init sequence, then writes whole lines.
// Define LCD_ARB_RR_EN for round-robin tie breaking; default build uses fixed priority to req0.
module lcd_line_arbiter
    import lcd_pkg::*;
#(
    parameter int E_DIV    = 5,
    parameter int CLR_WAIT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] char0,
    input  logic [7:0] char1,
    output logic [3:0] char_idx,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done,
    output logic       ready,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam int WW = $clog2(CLR_WAIT + 1);

    state_t          state, next_state;
    logic            slot_want, slot_load, slot_done;
    logic [WW-1:0]   wait_cnt;
    logic [3:0]      char_cnt;
    logic            pick0, pick1;
    logic [7:0]      next_byte;
`ifdef LCD_ARB_RR_EN
    logic            last1;
`endif

    lcd_write_slot #(.E_DIV(E_DIV)) u_slot (
        .clk   (clk),
        .rst   (rst),
        .want  (slot_want),
        .load  (slot_load),
        .done  (slot_done),
        .lcd_e (lcd_e)
    );

    assign lcd_rw = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT_FS;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        pick0      = 1'b0;
        pick1      = 1'b0;
        case (state)
            ST_INIT_FS:  if (slot_done) next_state = ST_INIT_ON;
            ST_INIT_ON:  if (slot_done) next_state = ST_INIT_EM;
            ST_INIT_EM:  if (slot_done) next_state = ST_INIT_CLR;
            ST_INIT_CLR: if (slot_done) next_state = ST_CLR_WAIT;
            ST_CLR_WAIT: if (wait_cnt == WW'(CLR_WAIT - 1)) next_state = ST_IDLE;
            ST_IDLE: begin
`ifdef LCD_ARB_RR_EN
                pick1 = req1 && (!req0 || !last1);
`else
                pick1 = req1 && !req0;
`endif
                pick0 = req0 && !pick1;
                if (pick0 || pick1) next_state = ST_ADDR;
            end
            ST_ADDR:     if (slot_done) next_state = ST_CHAR;
            ST_CHAR:     if (slot_done && char_cnt == LAST_CHAR) next_state = ST_FIN;
            ST_FIN:      next_state = ST_IDLE;
            default:     next_state = ST_INIT_FS;
        endcase

        slot_want = is_write(next_state);
        done      = (state == ST_FIN);

        // Expose the upcoming index during the last cycle of a char slot so the
        // requester's byte is valid at the edge where the next slot captures it.
        char_idx = char_cnt;
        if (state == ST_CHAR && slot_done && char_cnt != LAST_CHAR)
            char_idx = char_cnt + 4'd1;

        case (next_state)
            ST_INIT_FS:  next_byte = CMD_FUNC_SET;
            ST_INIT_ON:  next_byte = CMD_DISP_ON;
            ST_INIT_EM:  next_byte = CMD_ENTRY;
            ST_INIT_CLR: next_byte = CMD_CLEAR;
            ST_ADDR:     next_byte = pick1 ? CMD_ADDR_L2 : CMD_ADDR_L1;
            ST_CHAR:     next_byte = gnt1 ? char1 : char0;
            default:     next_byte = lcd_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            ready    <= 1'b0;
            wait_cnt <= '0;
            char_cnt <= '0;
`ifdef LCD_ARB_RR_EN
            last1    <= 1'b1;
`endif
        end else begin
            if (slot_load) begin
                lcd_data <= next_byte;
                lcd_rs   <= (next_state == ST_CHAR);
            end
            wait_cnt <= (state == ST_CLR_WAIT) ? wait_cnt + 1'b1 : '0;
            if (state == ST_CLR_WAIT && next_state == ST_IDLE) ready <= 1'b1;
            if (state == ST_IDLE && next_state == ST_ADDR) begin
                gnt0  <= pick0;
                gnt1  <= pick1;
`ifdef LCD_ARB_RR_EN
                last1 <= pick1;
`endif
            end
            if (state == ST_CHAR && slot_done) char_cnt <= char_cnt + 4'd1;
            if (state == ST_FIN) begin
                gnt0     <= 1'b0;
                gnt1     <= 1'b0;
                char_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Scoreboard bench for lcd_line_arbiter: stimulus pushes expected LCD bytes and grant lines,
// a negedge monitor pops and compares as the DUT strobes bytes and grants.
module tb_lcd_line_arbiter;

    localparam int E_DIV    = 2;
    localparam int CLR_WAIT = 8;
    localparam int XFER_CYC = 17 * 2 * E_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] char0, char1;
    logic [3:0] char_idx;
    logic       gnt0, gnt1, done, ready;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_line_arbiter #(.E_DIV(E_DIV), .CLR_WAIT(CLR_WAIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .char0    (char0),
        .char1    (char1),
        .char_idx (char_idx),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done     (done),
        .ready    (ready),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] str0 [16];
    logic [7:0] str1 [16];
    assign char0 = str0[char_idx];
    assign char1 = str1[char_idx];

    logic [8:0] exp_byte [$];   // {rs, data}
    int         exp_line [$];
    int         last_srv;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration rule.
    function automatic int winner(bit r0, bit r1);
        if (r0 && r1) begin
`ifdef LCD_ARB_RR_EN
            return (last_srv == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    task automatic push_xfer(int line);
        exp_line.push_back(line);
        exp_byte.push_back({1'b0, (line == 1) ? 8'hC0 : 8'h80});
        for (int i = 0; i < 16; i++)
            exp_byte.push_back({1'b1, (line == 1) ? str1[i] : str0[i]});
        last_srv = line;
    endtask

    task automatic rand_strings();
        for (int i = 0; i < 16; i++) begin
            str0[i] = 8'(8'h20 + $urandom_range(0, 94));
            str1[i] = 8'(8'h20 + $urandom_range(0, 94));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int W_READY = 0, W_GNT = 1, W_DONE = 2, W_IDLE = 3, W_G1C3 = 4, W_G0C7 = 5;

    function automatic bit sig(int which);
        case (which)
            W_READY: return ready;
            W_GNT:   return gnt0 | gnt1;
            W_DONE:  return done;
            W_IDLE:  return ready && !gnt0 && !gnt1;
            W_G1C3:  return gnt1 && (char_idx == 4'd3);
            W_G0C7:  return gnt0 && (char_idx == 4'd7);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(int which, int max, string name);
        int n = 0;
        while (!sig(which) && n < max) begin
            step();
            n++;
        end
        if (!sig(which)) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%s: got no event in %0d cycles, expected event", name, max);
        end
    endtask

    // Ready must follow the last lcd_e pulse of init by exactly CLR_WAIT low cycles.
    task automatic wait_ready_gap();
        int n = 0;
        int last_e = -1;
        while (!ready && n < 500) begin
            if (lcd_e) last_e = n;
            step();
            n++;
        end
        if (!ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_ready: got ready=0 after %0d cycles, expected ready=1", n);
        end else begin
            chk("clr_wait_gap", 32'(n - last_e - 1), 32'(CLR_WAIT));
        end
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        exp_byte.delete();
        exp_line.delete();
        last_srv = 1;
        step();
        chk("reset_outputs", {13'd0, lcd_e, lcd_rs, lcd_rw, lcd_data, gnt0, gnt1, done, ready, char_idx}, 32'd0);
        repeat (cycles - 1) step();
        rst = 1'b0;
        exp_byte.push_back({1'b0, 8'h3C});
        exp_byte.push_back({1'b0, 8'h0C});
        exp_byte.push_back({1'b0, 8'h06});
        exp_byte.push_back({1'b0, 8'h01});
    endtask

    // Monitor: byte strobes, slot shape, grants and done timing.
    logic       e_prev, g_prev, d_prev, timing;
    int         hi_cnt, tmr;
    logic [8:0] cur_byte, last_low;

    always @(negedge clk) begin
        if (rst) begin
            e_prev = 1'b0; g_prev = 1'b0; d_prev = 1'b0; timing = 1'b0;
            hi_cnt = 0; tmr = 0;
        end else begin
            chk("grant_legal", {30'd0, gnt0 & gnt1, (gnt0 | gnt1) & ~ready}, 32'd0);
            if (lcd_e && !e_prev) begin
                cur_byte = {lcd_rs, lcd_data};
                hi_cnt = 1;
                chk("setup_stable", {23'd0, cur_byte}, {23'd0, last_low});
                chk("lcd_rw", {31'd0, lcd_rw}, 32'd0);
                if (exp_byte.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL byte_unexpected: got %0h, expected no byte", cur_byte);
                end else begin
                    chk("lcd_byte", {23'd0, cur_byte}, {23'd0, exp_byte.pop_front()});
                end
            end else if (lcd_e) begin
                hi_cnt++;
                chk("hold_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, cur_byte});
            end else if (e_prev) begin
                chk("e_high_len", 32'(hi_cnt), 32'(E_DIV));
            end
            if (!lcd_e) last_low = {lcd_rs, lcd_data};

            if ((gnt0 | gnt1) && !g_prev) begin
                tmr = 0;
                timing = 1'b1;
                if (exp_line.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL grant_unexpected: got gnt=%b%b, expected none", gnt1, gnt0);
                end else begin
                    chk("gnt_line", {30'd0, gnt1, gnt0}, (exp_line.pop_front() == 1) ? 32'd2 : 32'd1);
                end
            end else if (timing) begin
                tmr++;
            end
            if (done) begin
                chk("done_latency", 32'(tmr), 32'(XFER_CYC));
                chk("done_pulse", {31'd0, d_prev}, 32'd0);
                chk("done_granted", {31'd0, gnt0 | gnt1}, 32'd1);
                timing = 1'b0;
            end
            e_prev = lcd_e;
            g_prev = gnt0 | gnt1;
            d_prev = done;
        end
    end

    initial begin
        last_srv = 1;
        last_low = '0;
        cur_byte = '0;
        rand_strings();

        // Power-up init sequence
        do_reset(3);
        wait_ready_gap();

        // Single-cycle req0 pulse writing "SSSS..."
        for (int i = 0; i < 16; i++) str0[i] = 8'h53;
        push_xfer(0);
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        wait_for(W_GNT, 10, "gnt_pulse");
        wait_for(W_DONE, XFER_CYC + 10, "done_pulse");
        step();

        // Both requests held through three transfers
        rand_strings();
        for (int k = 0; k < 3; k++) push_xfer(winner(1'b1, 1'b1));
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_for(W_DONE, XFER_CYC + 10, "done_tie");
            if (k == 2) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            step();
        end

        // req1 dropped mid-line must not abort the write
        rand_strings();
        push_xfer(1);
        req1 = 1'b1;
        wait_for(W_GNT, 10, "gnt_drop");
        wait_for(W_G1C3, XFER_CYC, "char3");
        req1 = 1'b0;
        wait_for(W_DONE, XFER_CYC + 10, "done_drop");
        step();

        // Random request patterns
        repeat (8) begin
            bit r0, r1;
            wait_for(W_IDLE, 20, "idle");
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            rand_strings();
            push_xfer(winner(r0, r1));
            req0 = r0;
            req1 = r1;
            step();
            req0 = 1'b0;
            req1 = 1'b0;
            wait_for(W_DONE, XFER_CYC + 10, "done_rand");
            step();
        end

        // Reset mid-line with both requests held through init
        rand_strings();
        push_xfer(0);
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        wait_for(W_G0C7, XFER_CYC, "char7");
        req0 = 1'b1;
        req1 = 1'b1;
        do_reset(3);
        push_xfer(winner(1'b1, 1'b1));
        wait_ready_gap();
        step();
        chk("gnt_after_ready", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_for(W_DONE, XFER_CYC + 10, "done_after_reset");
        repeat (5) step();

        chk("bytes_left", 32'(exp_byte.size()), 32'd0);
        chk("lines_left", 32'(exp_line.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_line_arbiter.md
LCD_LINE_ARBITER -- requirements
Module: lcd_line_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 Parameter E_DIV, default 5: clk cycles per lcd_e phase (low phase, then high phase).
REQ-003 Parameter CLR_WAIT, default 200: clk cycles of idle wait after the clear-display command.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req0  in  1  line-1 requester (game status) wants a 16-char write.
REQ-007 req1  in  1  line-2 requester (input echo) wants a 16-char write.
REQ-008 char0  in  8  ASCII byte from requester 0 at index char_idx.
REQ-009 char1  in  8  ASCII byte from requester 1 at index char_idx.
REQ-010 char_idx  out  4  character index 0..15 currently fetched.
REQ-011 gnt0, gnt1  out  1 each  grant; one-hot or zero.
REQ-012 done  out  1  one-cycle pulse when a granted line completes.
REQ-013 ready  out  1  high once the init sequence has completed.
REQ-014 lcd_e, lcd_rs, lcd_rw  out  1 each  LCD strobe, register select, read/write.
REQ-015 lcd_data  out  8  LCD data bus.

Function
REQ-016 Every LCD byte SHALL occupy one write slot of 2*E_DIV cycles: lcd_e is low for E_DIV cycles, then high for E_DIV cycles. lcd_rs, lcd_data and lcd_rw=0 SHALL be stable for the whole slot.
REQ-017 States: INIT_FS, INIT_ON, INIT_EM, INIT_CLR, CLR_WAIT, IDLE, ADDR, CHAR, FIN.
REQ-018 INIT bytes SHALL be written in this order, with rs=0: 0x3C, 0x0C, 0x06, 0x01.
REQ-019 After the 0x01 byte, the block SHALL wait CLR_WAIT cycles with lcd_e=0, then enter IDLE and set ready=1.
REQ-020 Requests SHALL be ignored before ready.
REQ-021 In IDLE, the block SHALL sample the requests and assert the grant on the next cycle; the grant then holds until FIN.
REQ-022 ADDR SHALL write 0x80 for gnt0 or 0xC0 for gnt1, with rs=0.
REQ-023 CHAR SHALL write 16 bytes with rs=1. lcd_data SHALL be the granted requester's char, captured at slot start for char_idx 0..15.
REQ-024 FIN SHALL pulse done for 1 cycle, drop the grant, return char_idx to 0, and go to IDLE.
REQ-025 A full transfer SHALL take 17*2*E_DIV cycles from grant to done.
REQ-026 A request deasserted mid-transfer SHALL NOT abort the transfer; the request is sampled only in IDLE.
REQ-027 A request still high at FIN SHALL be re-arbitrated in the following IDLE cycle.
REQ-028 If neither request is high, IDLE SHALL drive lcd_e=0 and hold the last data.

Reset
REQ-029 On rst, the block SHALL enter INIT_FS and clear all counters.
REQ-030 On rst, outputs SHALL take these values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, gnt0=gnt1=0, done=0, ready=0, char_idx=0.
REQ-031 rst asserted mid-transfer SHALL abandon the transfer at the next edge and re-run the full init sequence.

Configuration
REQ-032 With LCD_ARB_RR_EN defined, simultaneous requests SHALL alternate, granting the requester not served last. The last-served flag resets to requester 1, so requester 0 wins the first tie.
REQ-033 Without LCD_ARB_RR_EN, req0 SHALL always win ties (fixed priority).

Structure
REQ-034 Shared package lcd_pkg SHALL hold the LCD command constants (0x3C, 0x0C, 0x06, 0x01, 0x80, 0xC0) and the state encoding.
REQ-035 Sub-module lcd_write_slot SHALL implement the E_DIV phase counter and slot-done strobe. The arbiter SHALL instantiate it exactly once.

Verification (E_DIV=2, CLR_WAIT=8)
REQ-036 Release rst: expect the byte sequence 0x3C, 0x0C, 0x06, 0x01 with rs=0, each lcd_e high for 2 cycles, then 8 idle cycles, then ready=1.
REQ-037 req0 pulsed 1 cycle with char0="S" for all indices: expect gnt0, then 0x80 rs=0, then 16 bytes 0x53 rs=1, then done exactly 68 cycles after gnt0 rises.
REQ-038 req0 and req1 held high together, macro off: expect three consecutive transfers all on line 1 (0x80). Macro on: expect 0x80, 0xC0, 0x80.
REQ-039 req1 dropped after 3 chars: expect all 16 chars written and done pulsed.
REQ-040 rst asserted at char 7: expect reset output values next cycle, then a fresh 0x3C init.
REQ-041 Requests high during init: expect no grant before ready; gnt0 one cycle after ready.
